// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite responder memory.
package axi4lite_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_ADDR,
    W_GOT_DATA,
    W_RESP
  } write_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } read_state_t;

endpackage

// File: rtl/axi4lite_regmem.sv
// DEPTH x 32 storage: one byte-strobed write port and one registered read port.
// A same-cycle read and write of one word returns the pre-write contents.
module axi4lite_regmem
  import axi4lite_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [STRB_WIDTH-1:0]    wr_strb,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // The array itself carries no reset; only the read register does.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite responder memory with independent write and read FSMs.
// Optional AXIL_ADDR_CHECK_EN: out-of-window accesses get SLVERR instead of wrapping.
module axi4lite_slave_mem
  import axi4lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output write_state_t          dbg_wstate,
  output read_state_t           dbg_rstate
);

  // DEPTH is assumed to be a power of two so that the index wraps by truncation.
  localparam int                    IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH);

  // A transfer happens on a rising edge where VALID and READY are both high;
  // READY here depends only on FSM state, so a held VALID is accepted once.
  write_state_t          wstate_q, wstate_d;
  read_state_t           rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] cmt_addr, w_off, r_off;
  logic [DATA_WIDTH-1:0] cmt_data, mem_rd_data;
  logic [STRB_WIDTH-1:0] cmt_strb;
  logic                  w_in_range, r_in_range, mem_wr_en;
  logic [1:0]            w_resp, r_resp;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // ---------------- write FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wstate_q <= W_IDLE;
    else          wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_GOT_ADDR;
        else if (w_hs)     wstate_d = W_GOT_DATA;
      end
      W_GOT_ADDR: if (w_hs)   wstate_d = W_RESP;
      W_GOT_DATA: if (aw_hs)  wstate_d = W_RESP;
      W_RESP:     if (BREADY) wstate_d = W_IDLE;
      default:                wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_GOT_DATA);
    WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_GOT_ADDR);
    BVALID  = (wstate_q == W_RESP);
    BRESP   = bresp_q;
  end

  // ---------------- write datapath ----------------
  always_comb begin
    commit = 1'b0;
    case (wstate_q)
      W_IDLE:     commit = aw_hs & w_hs;
      W_GOT_ADDR: commit = w_hs;
      W_GOT_DATA: commit = aw_hs;
      default:    commit = 1'b0;
    endcase
  end

  // Whichever half arrived earlier comes from the holding registers.
  always_comb begin
    cmt_addr = (wstate_q == W_GOT_ADDR) ? waddr_q : AWADDR;
    cmt_data = (wstate_q == W_GOT_DATA) ? wdata_q : WDATA;
    cmt_strb = (wstate_q == W_GOT_DATA) ? wstrb_q : WSTRB;
    waddr_d  = aw_hs ? AWADDR : waddr_q;
    wdata_d  = w_hs  ? WDATA  : wdata_q;
    wstrb_d  = w_hs  ? WSTRB  : wstrb_q;
    bresp_d  = commit ? w_resp : bresp_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
    end
  end

  // ---------------- address decode ----------------
  assign w_off      = cmt_addr - BASE_ADDR;
  assign r_off      = ARADDR - BASE_ADDR;
  assign w_in_range = (w_off < SPAN);
  assign r_in_range = (r_off < SPAN);

`ifdef AXIL_ADDR_CHECK_EN
  assign mem_wr_en = commit & w_in_range;
  assign w_resp    = w_in_range ? RESP_OKAY : RESP_SLVERR;
  assign r_resp    = r_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign mem_wr_en = commit;
  assign w_resp    = RESP_OKAY;
  assign r_resp    = RESP_OKAY;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_off[1:0], w_off[ADDR_WIDTH-1:IDX_W+2],
                              r_off[1:0], r_off[ADDR_WIDTH-1:IDX_W+2],
                              w_in_range, r_in_range};

  // ---------------- read FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rstate_q <= R_IDLE;
    else          rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs)  rstate_d = R_RESP;
      R_RESP:  if (RREADY) rstate_d = R_IDLE;
      default:             rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (rstate_q == R_IDLE);
    RVALID  = (rstate_q == R_RESP);
    RRESP   = rresp_q;
    RDATA   = (rresp_q == RESP_SLVERR) ? '0 : mem_rd_data;
  end

  always_comb rresp_d = ar_hs ? r_resp : rresp_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rresp_q <= RESP_OKAY;
    else          rresp_q <= rresp_d;
  end

  axi4lite_regmem #(.DEPTH(DEPTH)) u_mem (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (mem_wr_en),
    .wr_idx  (w_off[IDX_W+1:2]),
    .wr_data (cmt_data),
    .wr_strb (cmt_strb),
    .rd_en   (ar_hs),
    .rd_idx  (r_off[IDX_W+1:2]),
    .rd_data (mem_rd_data)
  );

  assign dbg_wstate = wstate_q;
  assign dbg_rstate = rstate_q;

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Directed bench for axi4lite_slave_mem: driver tasks push expected B/R
// responses into queues that a negedge monitor pops and compares.
module tb_axi4lite_slave_mem;
  import axi4lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;
  write_state_t dbg_wstate;
  read_state_t  dbg_rstate;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [1:0]  exp_b;
  logic [33:0] exp_r;

  axi4lite_slave_mem dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .dbg_wstate(dbg_wstate), .dbg_rstate(dbg_rstate)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETN && BVALID && BREADY) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected", 64'(BRESP), 64'hFFFF);
      end else begin
        exp_b = exp_b_q.pop_front();
        check("bresp", 64'(BRESP), 64'(exp_b));
      end
    end
    if (ARESETN && RVALID && RREADY) begin
      if (exp_r_q.size() == 0) begin
        check("r_unexpected", 64'({RRESP, RDATA}), 64'hFFFF_FFFF_FFFF);
      end else begin
        exp_r = exp_r_q.pop_front();
        check("rresp_rdata", 64'({RRESP, RDATA}), 64'(exp_r));
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic aw_send(input logic [31:0] addr);
    logic ok = 1'b0;
    int   n  = 0;
    AWADDR = addr; AWVALID = 1'b1;
    while (!ok && n < 50) begin
      @(negedge ACLK); ok = AWREADY; n++;
      @(posedge ACLK);
    end
    #1 AWVALID = 1'b0;
    if (!ok) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
    logic ok = 1'b0;
    int   n  = 0;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    while (!ok && n < 50) begin
      @(negedge ACLK); ok = WREADY; n++;
      @(posedge ACLK);
    end
    #1 WVALID = 1'b0;
    if (!ok) check("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic ar_send(input logic [31:0] addr);
    logic ok = 1'b0;
    int   n  = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!ok && n < 50) begin
      @(negedge ACLK); ok = ARREADY; n++;
      @(posedge ACLK);
    end
    #1 ARVALID = 1'b0;
    if (!ok) check("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic next_cycle();
    @(posedge ACLK); #1;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] resp);
    exp_b_q.push_back(resp);
    fork
      aw_send(addr);
      w_send(data, strb);
    join
    @(negedge ACLK); check("bvalid_latency", 64'(BVALID), 64'd1);
    next_cycle();
  endtask

  task automatic read(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
    exp_r_q.push_back({resp, data});
    ar_send(addr);
    @(negedge ACLK); check("rvalid_latency", 64'(RVALID), 64'd1);
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_bresp",  64'(BRESP),  64'd0);
    check("rst_rresp",  64'(RRESP),  64'd0);
    check("rst_rdata",  64'(RDATA),  64'd0);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_readies", 64'({AWREADY, WREADY, ARREADY}), 64'b111);
    check("idle_states", 64'({dbg_wstate, dbg_rstate}), 64'({W_IDLE, R_IDLE}));
    next_cycle();

    // AW and W together, then readback
    write(32'h600, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    read(32'h600, RESP_OKAY, 32'hDEADBEEF);

    // W leads AW by three cycles
    exp_b_q.push_back(RESP_OKAY);
    w_send(32'hA5A5A5A5, 4'hF);
    @(negedge ACLK);
    check("wfirst_readies", 64'({AWREADY, WREADY, BVALID}), 64'b100);
    check("wfirst_state", 64'(dbg_wstate), 64'(W_GOT_DATA));
    next_cycle();
    next_cycle();
    aw_send(32'h704);
    @(negedge ACLK); check("wfirst_bvalid", 64'(BVALID), 64'd1);
    next_cycle();
    read(32'h704, RESP_OKAY, 32'hA5A5A5A5);

    // AW leads W
    exp_b_q.push_back(RESP_OKAY);
    aw_send(32'h904);
    @(negedge ACLK);
    check("awfirst_readies", 64'({AWREADY, WREADY, BVALID}), 64'b010);
    check("awfirst_state", 64'(dbg_wstate), 64'(W_GOT_ADDR));
    next_cycle();
    w_send(32'h0F0E0D0C, 4'hF);
    @(negedge ACLK); check("awfirst_bvalid", 64'(BVALID), 64'd1);
    next_cycle();
    read(32'h904, RESP_OKAY, 32'h0F0E0D0C);

    // Partial and empty strobes
    write(32'h800, 32'h11223344, 4'hF, RESP_OKAY);
    write(32'h800, 32'hAABBCCDD, 4'b0101, RESP_OKAY);
    read(32'h800, RESP_OKAY, 32'h11BB33DD);
    write(32'h800, 32'hFFFFFFFF, 4'b0000, RESP_OKAY);
    read(32'h800, RESP_OKAY, 32'h11BB33DD);

    // B backpressure
    BREADY = 1'b0;
    exp_b_q.push_back(RESP_OKAY);
    fork
      aw_send(32'h908);
      w_send(32'h12345678, 4'hF);
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_b_hold", 64'({BVALID, BRESP, AWREADY, WREADY}), 64'b1_00_0_0);
      next_cycle();
    end
    BREADY = 1'b1;
    next_cycle();
    @(negedge ACLK); check("bp_b_release", 64'({BVALID, AWREADY, WREADY}), 64'b011);
    next_cycle();

    // R backpressure
    RREADY = 1'b0;
    exp_r_q.push_back({RESP_OKAY, 32'h12345678});
    ar_send(32'h908);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_r_hold", 64'({RVALID, ARREADY, RRESP, RDATA}), {29'd0, 1'b1, 1'b0, 2'b00, 32'h12345678});
      next_cycle();
    end
    RREADY = 1'b1;
    next_cycle();
    @(negedge ACLK); check("bp_r_release", 64'({RVALID, ARREADY}), 64'b01);
    next_cycle();

    // Same-cycle write commit and read of one word returns old data
    exp_b_q.push_back(RESP_OKAY);
    exp_r_q.push_back({RESP_OKAY, 32'hDEADBEEF});
    fork
      aw_send(32'h600);
      w_send(32'h01020304, 4'hF);
      ar_send(32'h600);
    join
    @(negedge ACLK); check("rbw_valids", 64'({BVALID, RVALID}), 64'b11);
    next_cycle();
    read(32'h600, RESP_OKAY, 32'h01020304);
    read(32'h603, RESP_OKAY, 32'h01020304);

    // Window edge at 0x1000
    write(32'h000, 32'h0BADF00D, 4'hF, RESP_OKAY);
`ifdef AXIL_ADDR_CHECK_EN
    write(32'h1000, 32'h55667788, 4'hF, RESP_SLVERR);
    read(32'h1000, RESP_SLVERR, 32'h0);
    read(32'h000, RESP_OKAY, 32'h0BADF00D);
`else
    write(32'h1000, 32'h55667788, 4'hF, RESP_OKAY);
    read(32'h000, RESP_OKAY, 32'h55667788);
    read(32'h1000, RESP_OKAY, 32'h55667788);
`endif

    // Reset with a read response pending and a write half-accepted
    RREADY = 1'b0;
    ar_send(32'h604);
    aw_send(32'h600);
    @(negedge ACLK);
    check("pre_reset_states", 64'({dbg_wstate, dbg_rstate, RVALID}), 64'({W_GOT_ADDR, R_RESP, 1'b1}));
    #2 ARESETN = 1'b0;
    #1 check("mid_reset_valids", 64'({BVALID, RVALID}), 64'b00);
    check("mid_reset_states", 64'({dbg_wstate, dbg_rstate}), 64'({W_IDLE, R_IDLE}));
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    RREADY = 1'b1;
    next_cycle();
    write(32'h600, 32'hCAFEF00D, 4'hF, RESP_OKAY);
    read(32'h600, RESP_OKAY, 32'hCAFEF00D);

    repeat (3) next_cycle();
    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    check("r_queue_drained", 64'(exp_r_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
